// File: rtl/rat_io_bridge.sv
// rtl/rat_io_bridge.sv - RAT MCU port-bus bridge: output registers, synchronized inputs, debounced interrupt
module rat_io_bridge #(
  parameter int         DB_CYCLES = 4,
  parameter logic [7:0] LED_ID    = 8'h40,
  parameter logic [7:0] SSEG_ID   = 8'h81,
  parameter logic [7:0] ACK_ID    = 8'hF0,
  parameter logic [7:0] SW_ID     = 8'h20,
  parameter logic [7:0] BTN_ID    = 8'h24,
  parameter logic [7:0] STAT_ID   = 8'h30
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [7:0] PORT_ID,
  input  logic [7:0] OUT_PORT,
  input  logic       IO_STRB,
  output logic [7:0] IN_PORT,
  input  logic [7:0] SWITCHES,
  input  logic [3:0] BUTTONS,
  input  logic       INT_BTN,
  output logic [7:0] LEDS,
  output logic [7:0] SSEG,
  output logic       INT
);

  typedef enum logic [1:0] {DB_LOW, DB_RISE, DB_HIGH, DB_FALL} db_state_t;

  localparam logic [7:0] CNT_LAST = 8'(DB_CYCLES - 1);

  logic [7:0] sw_meta, sw_sync;
  logic [3:0] btn_meta, btn_sync;
  logic       int_meta, int_sync;
  db_state_t  db_state;
  logic [7:0] cnt;
  logic       db_level;
  logic       rise_evt;
  logic       pending;
  logic       ack_wr;

  assign ack_wr = IO_STRB && (PORT_ID == ACK_ID);
  assign INT    = pending;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sw_meta  <= '0;
      sw_sync  <= '0;
      btn_meta <= '0;
      btn_sync <= '0;
      int_meta <= 1'b0;
      int_sync <= 1'b0;
    end else begin
      sw_meta  <= SWITCHES;
      sw_sync  <= sw_meta;
      btn_meta <= BUTTONS;
      btn_sync <= btn_meta;
      int_meta <= INT_BTN;
      int_sync <= int_meta;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      LEDS <= '0;
      SSEG <= '0;
    end else if (IO_STRB) begin
      if (PORT_ID == LED_ID)  LEDS <= OUT_PORT;
      if (PORT_ID == SSEG_ID) SSEG <= OUT_PORT;
    end
  end

  // With DB_CYCLES=1 the counting states are skipped: the first differing sample commits.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      db_state <= DB_LOW;
      cnt      <= '0;
      db_level <= 1'b0;
      rise_evt <= 1'b0;
    end else begin
      rise_evt <= 1'b0;
      case (db_state)
        DB_LOW: begin
          if (int_sync) begin
            if (CNT_LAST == 8'd0) begin
              db_state <= DB_HIGH;
              db_level <= 1'b1;
              rise_evt <= 1'b1;
            end else begin
              cnt      <= 8'd1;
              db_state <= DB_RISE;
            end
          end
        end
        DB_RISE: begin
          if (!int_sync) begin
            db_state <= DB_LOW;
          end else if (cnt == CNT_LAST) begin
            db_state <= DB_HIGH;
            db_level <= 1'b1;
            rise_evt <= 1'b1;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        DB_HIGH: begin
          if (!int_sync) begin
            if (CNT_LAST == 8'd0) begin
              db_state <= DB_LOW;
              db_level <= 1'b0;
            end else begin
              cnt      <= 8'd1;
              db_state <= DB_FALL;
            end
          end
        end
        DB_FALL: begin
          if (int_sync) begin
            db_state <= DB_HIGH;
          end else if (cnt == CNT_LAST) begin
            db_state <= DB_LOW;
            db_level <= 1'b0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: db_state <= DB_LOW;
      endcase
    end
  end

  // A new event outranks an acknowledge landing on the same edge.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pending <= 1'b0;
    end else if (rise_evt) begin
      pending <= 1'b1;
    end else if (ack_wr) begin
      pending <= 1'b0;
    end
  end

  always_comb begin
    IN_PORT = 8'h00;
    if (PORT_ID == SW_ID)        IN_PORT = sw_sync;
    else if (PORT_ID == BTN_ID)  IN_PORT = {4'b0, btn_sync};
    else if (PORT_ID == STAT_ID) IN_PORT = {6'b0, db_level, pending};
  end

endmodule

// File: doc/rat_io_bridge.md
Name: rat_io_bridge

Overview:
- Peripheral bridge on the RAT MCU port bus: decodes PORT_ID, latches OUT_PORT writes into board output registers on IO_STRB, and drives IN_PORT from synchronized switch/button inputs.
- Also produces the MCU INT line from a debounced, edge-detected interrupt button, with a pending flag cleared by a software port write.
- Sits directly beside the MCU top: consumes OUT_PORT/IO_STRB/PORT_ID, feeds IN_PORT and INT.

Parameters:
- DB_CYCLES, 4: consecutive stable cycles required before the debounced interrupt level changes (min 1, max 255).
- LED_ID, 8'h40: output port ID for LEDS.
- SSEG_ID, 8'h81: output port ID for SSEG.
- ACK_ID, 8'hF0: output port ID whose write clears the interrupt pending flag (data ignored).
- SW_ID, 8'h20: input port ID returning SWITCHES.
- BTN_ID, 8'h24: input port ID returning BUTTONS.
- STAT_ID, 8'h30: input port ID returning status.

Ports:
- CLK  in  1  system clock, all state on rising edge
- RST_N  in  1  asynchronous active-low reset
- PORT_ID  in  8  port address from MCU
- OUT_PORT  in  8  write data from MCU
- IO_STRB  in  1  one-cycle write strobe from MCU
- IN_PORT  out  8  read data to MCU
- SWITCHES  in  8  asynchronous board switches
- BUTTONS  in  4  asynchronous board buttons
- INT_BTN  in  1  asynchronous interrupt button, bouncy
- LEDS  out  8  registered LED output
- SSEG  out  8  registered seven-segment output
- INT  out  1  interrupt request to MCU, registered

Behaviour:
- Reset (RST_N=0, async): LEDS=0, SSEG=0, INT=0, pending=0, sync flops=0, debounce FSM=LOW, counter=0. IN_PORT follows the mux below using reset register values, so it reads 8'h00 for every ID during reset.
- Writes: on a rising CLK with IO_STRB=1:
  - PORT_ID==LED_ID: LEDS<=OUT_PORT.
  - PORT_ID==SSEG_ID: SSEG<=OUT_PORT.
  - PORT_ID==ACK_ID: clear pending.
  - Any other ID is ignored.
  - Output is visible 1 cycle after the strobe edge. IO_STRB=0 means no write, regardless of PORT_ID.
- Reads: IN_PORT is combinational from PORT_ID and registered sources:
  - SW_ID: sw_sync.
  - BTN_ID: {4'b0, btn_sync}.
  - STAT_ID: {6'b0, db_level, pending}.
  - Otherwise: 8'h00.
- Synchronizers: SWITCHES, BUTTONS and INT_BTN each pass through 2 flops. A change appears on IN_PORT 2 rising edges after the input changes.
- Debounce FSM, on synchronized INT_BTN (s), with counter cnt:
  - LOW: if s=1, cnt<=1 and go to RISE; else stay.
  - RISE: if s=0, go to LOW. Else if cnt==DB_CYCLES-1, go to HIGH, set db_level=1, and pulse rise_evt for 1 cycle. Else cnt<=cnt+1.
  - HIGH: if s=0, cnt<=1 and go to FALL; else stay.
  - FALL: if s=1, go to HIGH. Else if cnt==DB_CYCLES-1, go to LOW and set db_level=0. Else cnt<=cnt+1.
  - Net effect: the level changes only after DB_CYCLES consecutive equal samples. Any bounce returns to the prior stable state with no event.
  - DB_CYCLES=1: the transition happens on the first differing sample.
  - cnt is 8 bits and never wraps, because it is bounded by DB_CYCLES-1.
- Pending/INT:
  - rise_evt sets pending. ACK write clears it.
  - If rise_evt and an ACK write occur on the same edge, set wins and pending stays 1.
  - INT = pending, registered. INT asserts the cycle after rise_evt.
  - A held button produces one event only. The falling debounce produces no event.
- RST_N asserted mid-debounce or while pending: everything returns to reset values immediately, with no spurious INT after release. A button still held at release produces a fresh event after 2+DB_CYCLES cycles.

Test Plan:
- Reset: hold RST_N=0 with INT_BTN=1 and SWITCHES=8'hFF; LEDS/SSEG/INT must be 0 and IN_PORT must read 8'h00 for SW_ID. Release RST_N; INT must rise at exactly 2+DB_CYCLES+1 cycles.
- Writes: PORT_ID=8'h40, OUT_PORT=8'hA5, IO_STRB=1 for 1 cycle -> LEDS=8'hA5 next cycle, SSEG unchanged. PORT_ID=8'h81, 8'h3C -> SSEG=8'h3C. PORT_ID=8'h55 -> no change. IO_STRB=0 with ID 8'h40 -> no change.
- Reads: SWITCHES=8'h5A -> IN_PORT=8'h5A at PORT_ID=8'h20 after 2 edges. BUTTONS=4'hB, PORT_ID=8'h24 -> 8'h0B. Unmapped ID 8'h99 -> 8'h00.
- Debounce, DB_CYCLES=4: INT_BTN toggles 1,0,1,0 with 1-cycle pulses -> no INT. Then held high 10 cycles -> INT=1 exactly once. STAT_ID read -> 8'h03.
- Acknowledge: with INT=1, write PORT_ID=8'hF0 -> INT=0 next cycle. Button still held -> INT stays 0. Release, re-press -> INT=1 again.
- Collision: time the ACK write on the same edge as rise_evt -> INT remains 1. A following ACK clears it.
